// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer.
// Fetches one- or two-byte instructions from a combinational instruction memory.
// Each instruction is presented to a consumer through a valid/ready handshake.
//
// Ports:
//   Clk, Reset_n     rising-edge clock, asynchronous active-low reset
//   Enable           fetch permission, only looked at when about to fetch an opcode
//   Mem_address      instruction memory address (always the current PC)
//   Mem_data         combinational read data for Mem_address
//   Redirect         one-cycle jump request, beats everything else
//   Redirect_addr    target PC for Redirect
//   Instr_valid      an instruction is on Instr_* (ISSUE state)
//   Instr_ready      consumer accepts the instruction
//   Instr_pc         address of the opcode byte
//   Instr_opcode     opcode byte
//   Instr_operand    operand byte, 8'h00 for one-byte instructions
//   Instr_len        0 = one-byte, 1 = two-byte
module instruction_fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Enable,
  output logic [7:0] Mem_address,
  input  logic [7:0] Mem_data,
  input  logic       Redirect,
  input  logic [7:0] Redirect_addr,
  output logic       Instr_valid,
  input  logic       Instr_ready,
  output logic [7:0] Instr_pc,
  output logic [7:0] Instr_opcode,
  output logic [7:0] Instr_operand,
  output logic       Instr_len
);

  typedef enum logic [1:0] {
    StFetchOp  = 2'd0,
    StFetchArg = 2'd1,
    StIssue    = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ipc_q, ipc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic       len_q, len_d;
  logic       two_byte;

  // Two-byte opcodes: top bits 11 or odd opcode.
  assign two_byte = (Mem_data[7:6] == 2'b11) || Mem_data[0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ipc_d     = ipc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;

    if (Redirect) begin
      // Redirect discards whatever is in flight, including an instruction being accepted.
      pc_d    = Redirect_addr;
      state_d = StFetchOp;
    end else begin
      case (state_q)
        StFetchOp: begin
          if (Enable) begin
            opcode_d = Mem_data;
            ipc_d    = pc_q;
            len_d    = two_byte;
            pc_d     = pc_q + 8'd1;
            if (two_byte) begin
              state_d = StFetchArg;
            end else begin
              operand_d = 8'h00;
              state_d   = StIssue;
            end
          end
        end
        StFetchArg: begin
          operand_d = Mem_data;
          pc_d      = pc_q + 8'd1;
          state_d   = StIssue;
        end
        StIssue: begin
          if (Instr_ready) begin
            state_d = StFetchOp;
          end
        end
        default: state_d = StFetchOp;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StFetchOp;
      pc_q      <= RESET_PC;
      ipc_q     <= 8'h00;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      len_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ipc_q     <= ipc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
    end
  end

  assign Mem_address   = pc_q;
  assign Instr_valid   = (state_q == StIssue);
  assign Instr_pc      = ipc_q;
  assign Instr_opcode  = opcode_q;
  assign Instr_operand = operand_q;
  assign Instr_len     = len_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer with a small combinational memory model.
module tb_instruction_fetch_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       Enable;
  logic [7:0] Mem_address;
  logic [7:0] Mem_data;
  logic       Redirect;
  logic [7:0] Redirect_addr;
  logic       Instr_valid;
  logic       Instr_ready;
  logic [7:0] Instr_pc;
  logic [7:0] Instr_opcode;
  logic [7:0] Instr_operand;
  logic       Instr_len;

  logic [7:0] mem [256];
  int n_checks;
  int n_fail;

  instruction_fetch_sequencer #(
    .RESET_PC(8'h00)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Enable       (Enable),
    .Mem_address  (Mem_address),
    .Mem_data     (Mem_data),
    .Redirect     (Redirect),
    .Redirect_addr(Redirect_addr),
    .Instr_valid  (Instr_valid),
    .Instr_ready  (Instr_ready),
    .Instr_pc     (Instr_pc),
    .Instr_opcode (Instr_opcode),
    .Instr_operand(Instr_operand),
    .Instr_len    (Instr_len)
  );

  assign Mem_data = mem[Mem_address];

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic check_issue(input string tag, input logic [7:0] pc, input logic [7:0] op,
                             input logic [7:0] arg, input logic len);
    check_eq({tag, ".valid"}, {31'd0, Instr_valid}, 32'd1);
    check_eq({tag, ".pc"}, {24'd0, Instr_pc}, {24'd0, pc});
    check_eq({tag, ".op"}, {24'd0, Instr_opcode}, {24'd0, op});
    check_eq({tag, ".arg"}, {24'd0, Instr_operand}, {24'd0, arg});
    check_eq({tag, ".len"}, {31'd0, Instr_len}, {31'd0, len});
  endtask

  task automatic check_idle(input string tag, input logic [7:0] addr);
    check_eq({tag, ".valid"}, {31'd0, Instr_valid}, 32'd0);
    check_eq({tag, ".addr"}, {24'd0, Mem_address}, {24'd0, addr});
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h00;
    mem[8'h01] = 8'hC0;
    mem[8'h02] = 8'hFF;
    mem[8'h03] = 8'h01;
    mem[8'h04] = 8'h05;

    Clk           = 1'b0;
    Reset_n       = 1'b0;
    Enable        = 1'b1;
    Redirect      = 1'b0;
    Redirect_addr = 8'h00;
    Instr_ready   = 1'b1;

    // Reset state
    #3;
    check_idle("rst", 8'h00);
    check_eq("rst.pc", {24'd0, Instr_pc}, 32'h0);
    check_eq("rst.op", {24'd0, Instr_opcode}, 32'h0);
    check_eq("rst.arg", {24'd0, Instr_operand}, 32'h0);
    check_eq("rst.len", {31'd0, Instr_len}, 32'h0);
    tick();
    check_idle("rst_hold", 8'h00);
    Reset_n = 1'b1;

    // Basic sequence: issues in cycles 2, 5, 8; Enable low in FETCH_ARG is ignored
    check_idle("seq.c1", 8'h00);
    tick();
    check_issue("seq.c2", 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    check_idle("seq.c3", 8'h01);
    tick();
    check_idle("seq.c4", 8'h02);
    Enable = 1'b0;
    tick();
    check_issue("seq.c5", 8'h01, 8'hC0, 8'hFF, 1'b1);
    check_eq("seq.c5.addr", {24'd0, Mem_address}, 32'h03);
    Enable = 1'b1;
    tick();
    check_idle("seq.c6", 8'h03);
    tick();
    check_idle("seq.c7", 8'h04);
    tick();
    check_issue("seq.c8", 8'h03, 8'h01, 8'h05, 1'b1);

    // Backpressure: ready low for 3 ISSUE cycles
    tick();
    do_reset();
    tick();
    check_issue("bp.c2", 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    Instr_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_issue("bp.hold", 8'h01, 8'hC0, 8'hFF, 1'b1);
      check_eq("bp.hold.addr", {24'd0, Mem_address}, 32'h03);
      tick();
    end
    check_issue("bp.c8", 8'h01, 8'hC0, 8'hFF, 1'b1);
    Instr_ready = 1'b1;
    tick();
    check_idle("bp.c9", 8'h03);
    tick();
    tick();
    check_issue("bp.c11", 8'h03, 8'h01, 8'h05, 1'b1);

    // Wrap: redirect to FF while accepting (ready=1 in ISSUE)
    mem[8'hFF] = 8'hC0;
    Redirect      = 1'b1;
    Redirect_addr = 8'hFF;
    tick();
    check_idle("wrap.r", 8'hFF);
    Redirect = 1'b0;
    tick();
    check_idle("wrap.arg", 8'h00);
    tick();
    check_issue("wrap.iss", 8'hFF, 8'hC0, 8'h00, 1'b1);
    check_eq("wrap.iss.addr", {24'd0, Mem_address}, 32'h01);
    tick();
    check_idle("wrap.next", 8'h01);
    mem[8'hFF] = 8'h00;

    // Redirect during FETCH_ARG of C0
    do_reset();
    tick();
    tick();
    tick();
    check_idle("rdarg.c4", 8'h02);
    Redirect      = 1'b1;
    Redirect_addr = 8'h03;
    tick();
    check_idle("rdarg.c5", 8'h03);
    Redirect = 1'b0;
    tick();
    check_idle("rdarg.c6", 8'h04);
    tick();
    check_issue("rdarg.c7", 8'h03, 8'h01, 8'h05, 1'b1);

    // Redirect in ISSUE without ready discards the instruction
    Instr_ready   = 1'b0;
    Redirect      = 1'b1;
    Redirect_addr = 8'h01;
    tick();
    check_idle("rdiss", 8'h01);
    Redirect    = 1'b0;
    Instr_ready = 1'b1;
    tick();
    check_idle("rdiss.arg", 8'h02);
    tick();
    check_issue("rdiss.iss", 8'h01, 8'hC0, 8'hFF, 1'b1);

    // Asynchronous reset mid-ISSUE
    do_reset();
    tick();
    tick();
    Instr_ready = 1'b0;
    tick();
    tick();
    check_issue("ares.pre", 8'h01, 8'hC0, 8'hFF, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_idle("ares", 8'h00);
    check_eq("ares.pc", {24'd0, Instr_pc}, 32'h0);
    check_eq("ares.op", {24'd0, Instr_opcode}, 32'h0);
    check_eq("ares.arg", {24'd0, Instr_operand}, 32'h0);
    check_eq("ares.len", {31'd0, Instr_len}, 32'h0);
    #1;
    Reset_n     = 1'b1;
    Instr_ready = 1'b1;
    check_idle("ares.rel", 8'h00);
    tick();
    check_issue("ares.first", 8'h00, 8'h00, 8'h00, 1'b0);

    // Redirect with Enable low, then 4 idle cycles, then resume from held PC
    Enable        = 1'b0;
    Redirect      = 1'b1;
    Redirect_addr = 8'h03;
    tick();
    check_idle("en.rd", 8'h03);
    Redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_idle("en.hold", 8'h03);
    end
    Enable = 1'b1;
    tick();
    check_idle("en.arg", 8'h04);
    tick();
    check_issue("en.iss", 8'h03, 8'h01, 8'h05, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
